// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens and the
// receiver lock-state encoding.
package tmds_pkg;

    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH,
        SLIP,
        LOCKED
    } lock_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: classifies a 10-bit symbol as a control
// token or a data symbol and recovers the control code or pixel byte.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] sym,
    output logic             is_ctrl,
    output logic [1:0]       ctrl,
    output logic [7:0]       data
);

    logic [7:0] q;

    // Undo the optional inversion before reversing the XOR/XNOR chain.
    assign q = sym[9] ? ~sym[7:0] : sym[7:0];

    always_comb begin
        is_ctrl = 1'b1;
        ctrl    = 2'b00;
        data    = 8'h00;
        case (sym)
            CTRL_TOKEN_00: ctrl = 2'b00;
            CTRL_TOKEN_01: ctrl = 2'b01;
            CTRL_TOKEN_10: ctrl = 2'b10;
            CTRL_TOKEN_11: ctrl = 2'b11;
            default: begin
                is_ctrl = 1'b0;
                data[0] = q[0];
                for (int i = 1; i < 8; i++) begin
                    data[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
                end
            end
        endcase
    end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: two-stage decode pipeline plus a word-alignment FSM
// that requests deserializer bit-slips until runs of control tokens appear.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN_LOCK  = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_SETTLE    = 16,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [SYM_W-1:0] tmds_in,
    output logic [7:0]       data_out,
    output logic [1:0]       control_out,
    output logic             ve_out,
    output logic             locked_out,
    output logic             bitslip_out
);

    localparam int TMR_MAX = (SEARCH_TIMEOUT > LOCK_TIMEOUT)
        ? ((SEARCH_TIMEOUT > SLIP_SETTLE) ? SEARCH_TIMEOUT : SLIP_SETTLE)
        : ((LOCK_TIMEOUT > SLIP_SETTLE) ? LOCK_TIMEOUT : SLIP_SETTLE);
    localparam int TMR_W = $clog2(TMR_MAX + 1);
    localparam int RUN_W = $clog2(CTRL_RUN_LOCK + 1);

    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SLIP_SETTLE - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(CTRL_RUN_LOCK);
    localparam logic [RUN_W-1:0] RUN_PRE     = RUN_W'(CTRL_RUN_LOCK - 1);

    logic [SYM_W-1:0] tmds_p1;
    logic             vld_p1;
    logic             is_ctrl_p1;
    logic [1:0]       ctrl_p1;
    logic [7:0]       data_p1;
    logic             tok_p1;
    logic             run_hit;
    logic             search_expired;

    lock_state_t      state;
    logic [TMR_W-1:0] timer;
    logic [RUN_W-1:0] run_cnt;

    // Stage 1: capture the raw symbol; vld_p1 keeps a symbol sampled during
    // reset from counting toward a new run.
    always_ff @(posedge clk_in) begin
        tmds_p1 <= tmds_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b1;
        end
    end

    tmds_symbol_decode u_symbol_decode (
        .sym     (tmds_p1),
        .is_ctrl (is_ctrl_p1),
        .ctrl    (ctrl_p1),
        .data    (data_p1)
    );

    // Stage 2: registered outputs, decoded regardless of lock state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out    <= 8'h00;
            control_out <= 2'b00;
            ve_out      <= 1'b0;
        end else begin
            data_out <= data_p1;
            ve_out   <= ~is_ctrl_p1;
            if (is_ctrl_p1) begin
                control_out <= ctrl_p1;
            end
        end
    end

    assign tok_p1         = vld_p1 & is_ctrl_p1;
    assign run_hit        = (state != SLIP) && tok_p1 && (run_cnt >= RUN_PRE);
    assign search_expired = (state == SEARCH) && (timer == SEARCH_LAST);
    // The slip request coincides with the SEARCH->SLIP transition cycle.
    assign bitslip_out    = search_expired && !run_hit;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= SEARCH;
            timer      <= '0;
            run_cnt    <= '0;
            locked_out <= 1'b0;
        end else begin
            if (state == SLIP || !tok_p1) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_FULL) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end

            case (state)
                SEARCH: begin
                    if (run_hit) begin
                        state      <= LOCKED;
                        timer      <= '0;
                        locked_out <= 1'b1;
                    end else if (timer == SEARCH_LAST) begin
                        state <= SLIP;
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                SLIP: begin
                    if (timer == SETTLE_LAST) begin
                        state <= SEARCH;
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                LOCKED: begin
                    if (run_hit) begin
                        timer <= '0;
                    end else if (timer == LOCK_LAST) begin
                        state      <= SEARCH;
                        timer      <= '0;
                        locked_out <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    state      <= SEARCH;
                    timer      <= '0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: behavioural TMDS encoder feeding the
// decoder, with a cycle model of the alignment rules and directed scenarios.
module tb_tmds_decoder;

    localparam int RUN = 8;
    localparam int ST  = 4096;
    localparam int SS  = 16;
    localparam int LT  = 4096;

    localparam int HUNT   = 0;
    localparam int SETTLE = 1;
    localparam int HOLD   = 2;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [9:0] tmds_in;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       locked_out;
    logic       bitslip_out;

    tmds_decoder #(
        .CTRL_RUN_LOCK  (RUN),
        .SEARCH_TIMEOUT (ST),
        .SLIP_SETTLE    (SS),
        .LOCK_TIMEOUT   (LT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .tmds_in     (tmds_in),
        .data_out    (data_out),
        .control_out (control_out),
        .ve_out      (ve_out),
        .locked_out  (locked_out),
        .bitslip_out (bitslip_out)
    );

    always #5 clk_in = ~clk_in;

    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};

    int n_assert = 0;
    int n_fail   = 0;
    int enc_disp = 0;

    // Reference model of the receiver, advanced once per clock edge.
    int         m_phase = HUNT;
    int         m_streak = 0;
    int         m_quiet = 0;
    bit         m_p1_valid = 0;
    bit         m_p1_tok = 0;
    bit         m_p1_known = 0;
    logic [1:0] m_p1_code = 2'b00;
    logic [7:0] m_p1_byte = 8'h00;
    logic [7:0] e_data = 8'h00;
    logic [1:0] e_ctrl = 2'b00;
    bit         e_ve = 0;
    bit         e_known = 1;
    bit         m_exp_slip = 0;

    int scen_tick, lock_rise, lock_fall, slip_cnt, slip_first, slip_last;
    bit prev_locked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Standard DVI 8b/10b video-data encoder with running disparity.
    function automatic logic [9:0] enc_data(input logic [7:0] d);
        logic [8:0] qm;
        int n1d, n1q, n0q;
        logic [9:0] o;
        n1d = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_disp == 0 || n1q == n0q) begin
            o = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (!qm[8]) enc_disp += n0q - n1q;
            else        enc_disp += n1q - n0q;
        end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            enc_disp += (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            enc_disp += (qm[8] ? 0 : -2) + n1q - n0q;
        end
        return o;
    endfunction

    function automatic bit is_token(input logic [9:0] w, output logic [1:0] code);
        is_token = 1'b0;
        code = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (w === tok_tab[k]) begin
                is_token = 1'b1;
                code = 2'(k);
            end
        end
    endfunction

    function automatic logic [9:0] rotr(input logic [9:0] w, input int r);
        logic [19:0] d;
        d = {w, w} >> r;
        return d[9:0];
    endfunction

    function automatic bit model_hit();
        return (m_phase != SETTLE) && m_p1_valid && m_p1_tok && (m_streak + 1 >= RUN);
    endfunction

    task automatic tick(input logic [9:0] sym, input bit known, input logic [7:0] b, input bit rst_v);
        bit hit, tok;
        logic [1:0] code;
        int cyc;
        rst_in  = rst_v;
        tmds_in = sym;
        @(posedge clk_in);
        if (rst_v) begin
            m_phase = HUNT; m_streak = 0; m_quiet = 0;
            e_data = 8'h00; e_ctrl = 2'b00; e_ve = 0; e_known = 1;
        end else begin
            hit = model_hit();
            e_ve    = !m_p1_tok;
            e_known = m_p1_known;
            e_data  = m_p1_tok ? 8'h00 : m_p1_byte;
            if (m_p1_tok) e_ctrl = m_p1_code;
            if (m_phase == SETTLE)            m_streak = 0;
            else if (m_p1_valid && m_p1_tok)  m_streak++;
            else                              m_streak = 0;
            case (m_phase)
                HUNT: begin
                    if (hit) begin m_phase = HOLD; m_quiet = 0; end
                    else if (m_quiet == ST - 1) begin m_phase = SETTLE; m_quiet = 0; end
                    else m_quiet++;
                end
                SETTLE: begin
                    if (m_quiet == SS - 1) begin m_phase = HUNT; m_quiet = 0; end
                    else m_quiet++;
                end
                default: begin
                    if (hit) m_quiet = 0;
                    else if (m_quiet == LT - 1) begin m_phase = HUNT; m_quiet = 0; end
                    else m_quiet++;
                end
            endcase
        end
        tok = is_token(sym, code);
        m_p1_valid = !rst_v;
        m_p1_tok   = tok;
        m_p1_code  = code;
        m_p1_byte  = b;
        m_p1_known = known | tok;
        #1;
        m_exp_slip = (m_phase == HUNT) && (m_quiet == ST - 1) && !model_hit();
        chk("locked", 32'(locked_out), 32'(m_phase == HOLD));
        chk("bitslip", 32'(bitslip_out), 32'(m_exp_slip));
        chk("ve", 32'(ve_out), 32'(e_ve));
        chk("control", 32'(control_out), 32'(e_ctrl));
        if (e_known) chk("data", 32'(data_out), 32'(e_data));
        cyc = scen_tick + 1;
        if (locked_out && !prev_locked && lock_rise < 0) lock_rise = cyc;
        if (!locked_out && prev_locked && lock_fall < 0) lock_fall = cyc;
        if (bitslip_out) begin
            slip_cnt++;
            if (slip_first < 0) slip_first = cyc;
            slip_last = cyc;
        end
        prev_locked = locked_out;
        scen_tick++;
    endtask

    task automatic start_scen();
        scen_tick = 0; lock_rise = -1; lock_fall = -1;
        slip_cnt = 0; slip_first = -1; slip_last = -1;
        prev_locked = locked_out;
    endtask

    task automatic send_tok(input logic [1:0] c);
        enc_disp = 0;
        tick(tok_tab[c], 1'b1, 8'h00, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick(enc_data(b), 1'b1, b, 1'b0);
    endtask

    task automatic reset_tick(input logic [7:0] b);
        tick(enc_data(b), 1'b1, b, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bytes [5] = '{8'h00, 8'hFF, 8'h55, 8'hA5, 8'h3C};
        int rot;
        rst_in  = 1'b1;
        tmds_in = 10'd0;
        start_scen();

        // Reset state
        reset_tick(8'h80);
        reset_tick(8'h80);
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_control", 32'(control_out), 32'h0);
        chk("rst_ve", 32'(ve_out), 32'h0);
        chk("rst_locked", 32'(locked_out), 32'h0);
        chk("rst_bitslip", 32'(bitslip_out), 32'h0);

        // Encoder loopback
        start_scen();
        repeat (20) send_tok(2'b01);
        for (int j = 0; j < 5; j++) send_byte(bytes[j]);
        send_byte(8'h11);
        chk("loop_lock_cycle", 32'(lock_rise), 32'd9);
        chk("loop_last_byte", 32'(data_out), 32'h3C);
        chk("loop_ve", 32'(ve_out), 32'h1);
        chk("loop_ctrl_hold", 32'(control_out), 32'h1);

        // Exhaustive decode with both disparity histories, then each token
        for (int b = 0; b < 256; b++) begin
            enc_disp = 4;
            send_byte(8'(b));
            enc_disp = -4;
            send_byte(8'(b));
        end
        for (int c = 0; c < 4; c++) begin
            send_tok(2'(c));
            send_byte(8'h5A);
            send_byte(8'hC3);
        end

        // Randomised bursts of tokens and data
        for (int r = 0; r < 300; r++) begin
            repeat ($urandom_range(1, 12)) send_tok(2'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 5)) send_byte(8'($urandom));
        end

        // Lock loss
        repeat (30) send_tok(2'b00);
        chk("loss_pre_locked", 32'(locked_out), 32'h1);
        start_scen();
        repeat (8200) send_byte(8'h80);
        chk("loss_fall_cycle", 32'(lock_fall), 32'd4097);
        chk("loss_slip_cycle", 32'(slip_first), 32'd8192);
        chk("loss_slip_count", 32'(slip_cnt), 32'd1);

        // Short runs never lock
        reset_tick(8'h80);
        start_scen();
        for (int r = 0; r < 512; r++) begin
            repeat (7) send_tok(2'b10);
            send_byte(8'($urandom));
        end
        chk("short_no_lock", 32'(lock_rise), 32'hFFFF_FFFF);
        chk("short_slip_cycle", 32'(slip_first), 32'd4095);
        chk("short_slip_count", 32'(slip_cnt), 32'd1);

        // Reset mid-lock
        repeat (30) send_tok(2'b11);
        chk("rml_pre_locked", 32'(locked_out), 32'h1);
        reset_tick(8'hC3);
        chk("rml_data", 32'(data_out), 32'h0);
        chk("rml_control", 32'(control_out), 32'h0);
        chk("rml_ve", 32'(ve_out), 32'h0);
        chk("rml_locked", 32'(locked_out), 32'h0);
        chk("rml_bitslip", 32'(bitslip_out), 32'h0);
        start_scen();
        repeat (12) send_tok(2'b11);
        chk("rml_relock_cycle", 32'(lock_rise), 32'd9);

        // Misalignment: stream rotated by 3 bits, one bit recovered per slip
        reset_tick(8'h80);
        start_scen();
        rot = 3;
        for (int k = 0; k < 14000 && !locked_out; k++) begin
            tick(rotr(tok_tab[1], rot), rot == 0, 8'h00, 1'b0);
            if (m_exp_slip) rot = (rot + 9) % 10;
        end
        chk("mis_locked", 32'(locked_out), 32'h1);
        chk("mis_slip_count", 32'(slip_cnt), 32'd3);
        chk("mis_first_slip", 32'(slip_first), 32'd4095);
        chk("mis_slip_span", 32'(slip_last - slip_first), 32'(2 * (ST + SS)));
        chk("mis_relock", 32'(lock_rise - slip_last), 32'd25);
        repeat (4) send_tok(2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
